// File: rtl/mask_pkg.sv
// Shared constants, FSM state type and config helpers for the activation
// window sequencer.
package mask_pkg;

   localparam int RAM_ROW_DEF    = 33;
   localparam int DATA_WIDTH_DEF = 64;
   localparam int PE_MAC_DEF     = 14;
   localparam int K_MAX_DEF      = 7;
   localparam int S_MAX_DEF      = 3;
   localparam int P_MAX_DEF      = 3;

   localparam int TAP_W = 3;   // kernel_size / tap index width
   localparam int CFG_W = 2;   // stride / pad width

   typedef enum logic {
      IDLE,
      SCAN
   } state_e;

   function automatic logic cfg_legal(input int k, input int s, input int p,
                                      input int ram_row, input int k_max,
                                      input int s_max, input int p_max);
      return (k >= 1) && (k <= k_max) && (s >= 1) && (s <= s_max) &&
             (p <= p_max) && (ram_row + 2 * p >= k);
   endfunction

   // Number of output positions that fit the padded window, capped at the lane count.
   function automatic int calc_n_out(input int k, input int s, input int p,
                                     input int ram_row, input int pe_mac);
      int n;
      if ((s <= 0) || (ram_row + 2 * p < k)) return 0;
      n = (ram_row + 2 * p - k) / s + 1;
      return (n < pe_mac) ? n : pe_mac;
   endfunction

endpackage

// File: rtl/mask_lane_sel.sv
// One output lane: picks the window row for (lane, tap) or zero when the
// position falls in the padding or beyond n_out.
module mask_lane_sel
   import mask_pkg::*;
#(
   parameter int DATA_W  = DATA_WIDTH_DEF,
   parameter int RAM_ROW = RAM_ROW_DEF,
   parameter int LANE    = 0,
   parameter int NOUT_W  = 4
) (
   input  logic [RAM_ROW*DATA_W-1:0] win_i,
   input  logic [TAP_W-1:0]          tap_i,
   input  logic [CFG_W-1:0]          stride_i,
   input  logic [CFG_W-1:0]          pad_i,
   input  logic [NOUT_W-1:0]         n_out_i,
   output logic [DATA_W-1:0]         data_o,
   output logic                      nz_o
);

   int   src;
   logic hit;

   always_comb begin
      src    = LANE * int'(stride_i) + int'(tap_i) - int'(pad_i);
      hit    = (LANE < int'(n_out_i)) && (src >= 0) && (src < RAM_ROW);
      data_o = '0;
      if (hit) data_o = win_i[src*DATA_W +: DATA_W];
   end

   assign nz_o = |data_o;

endmodule

// File: rtl/mask_window_seq.sv
// Captures one window of activation rows and streams one beat per kernel tap
// to the PE array over a valid/ready handshake.
module mask_window_seq
   import mask_pkg::*;
#(
   parameter int Ram_Row    = RAM_ROW_DEF,
   parameter int Data_Width = DATA_WIDTH_DEF,
   parameter int Pe_Mac     = PE_MAC_DEF,
   parameter int K_MAX      = K_MAX_DEF,
   parameter int S_MAX      = S_MAX_DEF,
   parameter int P_MAX      = P_MAX_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [TAP_W-1:0]              kernel_size,
   input  logic [CFG_W-1:0]              stride,
   input  logic [CFG_W-1:0]              pad,
   input  logic                          din_valid,
   output logic                          din_ready,
   input  logic [Data_Width*Ram_Row-1:0] din,
   input  logic                          tready,
   output logic                          sel_valid,
   output logic [Pe_Mac*Data_Width-1:0]  select_act,
   output logic [Pe_Mac-1:0]             lane_nz,
   output logic [TAP_W-1:0]              sel_tap,
   output logic                          sel_last,
   output logic                          cfg_err
);

   localparam int NOUT_W = $clog2(Pe_Mac + 1);

   state_e                        state_q, state_d;
   logic [Data_Width*Ram_Row-1:0] win_q;
   logic [TAP_W-1:0]              kern_q, tap_q;
   logic [CFG_W-1:0]              stride_q, pad_q;
   logic [NOUT_W-1:0]             nout_q;
   logic                          valid_q, last_q, err_q;
   logic [Pe_Mac*Data_Width-1:0]  act_q;
   logic [Pe_Mac-1:0]             nz_q;

   logic                          cfg_ok, advance, capture, load, valid_d, err_d;
   logic [NOUT_W-1:0]             nout_in;

   assign cfg_ok  = cfg_legal(int'(kernel_size), int'(stride), int'(pad),
                              Ram_Row, K_MAX, S_MAX, P_MAX);
   assign nout_in = NOUT_W'(calc_n_out(int'(kernel_size), int'(stride), int'(pad),
                                       Ram_Row, Pe_Mac));
   assign advance = valid_q && tready;

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: registers take non-blocking (<=) so every flop samples pre-edge values.
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE: if (din_valid && cfg_ok) state_d = SCAN;
         SCAN: if (advance && last_q)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      din_ready = (state_q == IDLE);
      capture   = din_ready && din_valid && cfg_ok;
      err_d     = din_ready && din_valid && !cfg_ok;
      load      = capture || (state_q == SCAN && advance && !last_q);
      valid_d   = valid_q;
      if (load)                  valid_d = 1'b1;
      else if (advance && last_q) valid_d = 1'b0;
   end

   // While idle the lanes look straight at din so beat 0 is ready on the accept edge.
   logic [Data_Width*Ram_Row-1:0] win_d;
   logic [TAP_W-1:0]              tap_d, kern_d;
   logic [CFG_W-1:0]              stride_d, pad_d;
   logic [NOUT_W-1:0]             nout_d;
   logic                          last_d;
   logic [Pe_Mac*Data_Width-1:0]  act_d;
   logic [Pe_Mac-1:0]             nz_d;

   always_comb begin
      if (state_q == IDLE) begin
         win_d = din;   tap_d = '0;                   kern_d = kernel_size;
         stride_d = stride; pad_d = pad;               nout_d = nout_in;
      end else begin
         win_d = win_q; tap_d = tap_q + TAP_W'(1);    kern_d = kern_q;
         stride_d = stride_q; pad_d = pad_q;           nout_d = nout_q;
      end
      last_d = (tap_d == kern_d - TAP_W'(1));
   end

   for (genvar p = 0; p < Pe_Mac; p++) begin : g_lane
      mask_lane_sel #(
         .DATA_W (Data_Width),
         .RAM_ROW(Ram_Row),
         .LANE   (p),
         .NOUT_W (NOUT_W)
      ) u_lane (
         .win_i   (win_d),
         .tap_i   (tap_d),
         .stride_i(stride_d),
         .pad_i   (pad_d),
         .n_out_i (nout_d),
         .data_o  (act_d[p*Data_Width +: Data_Width]),
         .nz_o    (nz_d[p])
      );
   end

   // NOTE: window/config storage has no reset; it is always written before it is read.
   always_ff @(posedge clk) begin
      if (capture) begin
         win_q    <= din;
         kern_q   <= kernel_size;
         stride_q <= stride;
         pad_q    <= pad;
         nout_q   <= nout_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         tap_q   <= '0;
         last_q  <= 1'b0;
         act_q   <= '0;
         nz_q    <= '0;
      end else begin
         valid_q <= valid_d;
         err_q   <= err_d;
         if (load) begin
            tap_q  <= tap_d;
            last_q <= last_d;
            act_q  <= act_d;
            nz_q   <= nz_d;
         end
      end
   end

   assign sel_valid  = valid_q;
   assign select_act = act_q;
   assign lane_nz    = nz_q;
   assign sel_tap    = tap_q;
   assign sel_last   = last_q;
   assign cfg_err    = err_q;

endmodule

// File: doc/mask_window_seq.md
# mask_window_seq

Parametrised successor to the activation mask stage: captures one window of `Ram_Row` activation rows, then sequences through kernel taps. Each output beat carries `Pe_Mac` lane-selected rows. Adds zero padding, runtime kernel/stride/pad, a valid/ready output handshake, per-lane nonzero flags for sparse skipping, and config checking. Sits between the activation line RAM and the PE array.

## Interface
- `Ram_Row`, 33, rows presented on `din`
- `Data_Width`, 64, bits per row (16 × 4-bit activations)
- `Pe_Mac`, 14, output lanes (PE MACs)
- `K_MAX`, 7, largest legal kernel size
- `S_MAX`, 3, largest legal stride
- `P_MAX`, 3, largest legal pad

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `kernel_size`  in  3  taps per window, legal 1..K_MAX; sampled on din accept
- `stride`  in  2  legal 1..S_MAX; sampled on din accept
- `pad`  in  2  leading zero rows, legal 0..P_MAX; sampled on din accept
- `din_valid`  in  1  window present
- `din_ready`  out  1  block idle, will accept window
- `din`  in  Data_Width*Ram_Row  row r at `[r*Data_Width +: Data_Width]`
- `tready`  in  1  downstream accepts beat
- `sel_valid`  out  1  beat valid
- `select_act`  out  Pe_Mac*Data_Width  lane p at `[p*Data_Width +: Data_Width]`
- `lane_nz`  out  Pe_Mac  lane p carries nonzero data
- `sel_tap`  out  3  tap index k of current beat
- `sel_last`  out  1  beat is final tap (k = kernel_size-1)
- `cfg_err`  out  1  one-cycle pulse, illegal config consumed

## Operation
- FSM states are IDLE and SCAN.
- IDLE: `din_ready`=1. On `din_valid`, capture `din` and config.
  - Legal config: compute `n_out` = min(Pe_Mac, (Ram_Row + 2*pad − kernel_size)/stride + 1), integer floor. Load beat k=0 into the output register and go to SCAN.
  - Illegal config (kernel 0 or > K_MAX, stride 0, pad > P_MAX, or Ram_Row+2*pad < kernel_size): pulse `cfg_err` and stay in IDLE. No beat is emitted.
- Lane selection for tap k and lane p: src = p*stride + k − pad, evaluated signed at ≥ $clog2(Ram_Row)+3 bits.
  - Lane data is row src if 0 ≤ src < Ram_Row and p < n_out; otherwise zero.
- `lane_nz[p]` = |lane data.
- SCAN: `sel_valid`=1 and `din_ready`=0.
  - On `sel_valid & tready`, if k < kernel_size−1, load tap k+1.
  - Otherwise clear `sel_valid` and return to IDLE.
- With no handshake, all outputs hold stable. This is a hard AXI-style rule: `tready` may toggle freely, and the beat never changes or drops.
- Reset (`rst`=0, any state, including mid-SCAN): asynchronously enter IDLE. The captured window is discarded.

## Timing
- Reset values: `din_ready`=1 after release; `sel_valid`=0, `select_act`=0, `lane_nz`=0, `sel_tap`=0, `sel_last`=0, `cfg_err`=0.
- Accept at edge T → beat k=0 visible after edge T (registered, latency 1).
- At full throughput (`tready` held high), one beat per cycle. A window takes kernel_size cycles plus one IDLE bubble before the next accept.
- `din_ready` is combinational from state only. `din_ready` never depends on `din_valid` or `tready`.
- `sel_last` and `sel_tap` change only with the beat they describe.
- A `cfg_err` pulse lands in the cycle after the illegal accept, with `sel_valid` held 0.

## Structure
- Package `mask_pkg` holds:
  - default parameter constants;
  - the state enum {IDLE, SCAN};
  - the `TAP_W`/`CFG_W` widths;
  - a function computing `n_out`.
- Sub-module `mask_lane_sel` is one per lane via generate. Inputs are the window, tap, stride, pad and n_out; outputs are the lane data and the nz bit.
- The top holds the FSM, the config/window registers and the output register.

## Test plan
- Rows `din` row i = {8{i[7:0]}}, k=3 s=1 p=0, `tready`=1 → 3 beats. Beat k has lane p = row p+k; beat 2 lane 13 = row 15. `sel_last` is set on beat 2 only. `din_ready` returns to 1 one cycle later.
- k=7 s=2 p=0 → `n_out`=14, 7 beats. Beat 6 lane 13 = row 32 = 64'h2020…20. Beat 0 lane 0 = 0 with `lane_nz[0]`=0.
- k=3 s=1 p=1 → beat 0 lane 0 is zero pad with `lane_nz[0]`=0, and beat 0 lane 1 = row 0. k=5 s=3 p=3 → `n_out`=12 (floor((33+6−5)/3)+1), so lanes 12–13 are zero on every beat.
- Toggle `tready` pseudo-randomly → every beat is held stable while stalled. Exactly kernel_size beats arrive, taps appear in order 0..kernel_size−1, and none is duplicated.
- Drive stride=0, then kernel_size=0, then pad=1 with kernel_size=7, stride=1 (legal): first two each give one `cfg_err` pulse and no `sel_valid`; third gives `n_out`=14 and 7 beats.
- Assert `rst`=0 mid-SCAN (beat 2 of 7) → outputs go to reset values immediately. After release, a new window is processed from tap 0.
